sipo_deser: RTL and testbench

Parametrised serial-in/parallel-out deserializer. It extends the fixed 4-bit SIPO shift register with:
- configurable word width, lane count (bits per clock) and bit order;
- a beat counter that frames words;
- a valid/ready output holding register with overrun detection.

It sits between a serial source (bit-stream receiver, SPI-like front end) and word-oriented downstream logic.

---
 rtl/sipo_pkg.sv | 29 ++
 rtl/sipo_out_reg.sv | 57 +++++
 rtl/sipo_deser.sv | 89 ++++++++
 tb/tb_sipo_deser.sv | 203 ++++++++++++++++++++
 4 files changed

// File: rtl/sipo_pkg.sv
`default_nettype none
// ============================================================================
// Module   : sipo_pkg
// Purpose  : Shared types and parameter derivations for the sipo_deser block.
// Revision : 1.0
// ============================================================================
package sipo_pkg;

    typedef enum logic [0:0] {
        OUT_EMPTY = 1'b0,
        OUT_FULL  = 1'b1
    } out_state_t;

    function automatic int beats_of(input int width, input int lanes);
        return width / lanes;
    endfunction

    // A single-beat word still needs a one-bit counter to keep ports legal.
    function automatic int cnt_width(input int beats);
        return (beats <= 1) ? 1 : $clog2(beats);
    endfunction

    function automatic bit params_legal(input int width, input int lanes);
        return (lanes == 1 || lanes == 2 || lanes == 4 || lanes == 8) &&
               (lanes <= width) && ((width % lanes) == 0);
    endfunction

endpackage
`default_nettype wire

// File: rtl/sipo_out_reg.sv
`default_nettype none
// ============================================================================
// Module   : sipo_out_reg
// Purpose  : Valid/ready holding register for completed words, with sticky
//            overrun when a word arrives while the held one is not consumed.
// Revision : 1.0
// ============================================================================
module sipo_out_reg
    import sipo_pkg::*;
#(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             clr,
    input  logic             load,
    input  logic [WIDTH-1:0] data,
    input  logic             ready,
    output logic [WIDTH-1:0] dout,
    output logic             dout_valid,
    output logic             overrun
);

    out_state_t r_state;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= OUT_EMPTY;
            dout    <= '0;
            overrun <= 1'b0;
        end else begin
            case (r_state)
                OUT_EMPTY: begin
                    if (load) begin
                        dout    <= data;
                        r_state <= OUT_FULL;
                    end
                end
                OUT_FULL: begin
                    if (load) begin
                        // Consumed-and-reloaded keeps FULL; otherwise the new word is lost.
                        if (ready) dout    <= data;
                        else       overrun <= 1'b1;
                    end else if (ready) begin
                        r_state <= OUT_EMPTY;
                    end
                end
                default: r_state <= OUT_EMPTY;
            endcase
            if (clr) overrun <= 1'b0;
        end
    end

    assign dout_valid = (r_state == OUT_FULL);

endmodule
`default_nettype wire

// File: rtl/sipo_deser.sv
`default_nettype none
// ============================================================================
// Module   : sipo_deser
// Purpose  : Parametrised serial-in/parallel-out deserializer with beat
//            framing and a valid/ready output holding register.
// Revision : 1.0
// ============================================================================
module sipo_deser
    import sipo_pkg::*;
#(
    parameter int WIDTH     = 8,
    parameter int LANES     = 1,
    parameter bit MSB_FIRST = 1'b1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             en,
    input  logic [LANES-1:0] din,
    input  logic             clr,
    output logic [WIDTH-1:0] q,
    output logic [WIDTH-1:0] dout,
    output logic             dout_valid,
    input  logic             dout_ready,
    output logic             overrun
);

    localparam int             BEATS     = beats_of(WIDTH, LANES);
    localparam int             CNT_W     = cnt_width(BEATS);
    localparam logic [CNT_W-1:0] LAST_BEAT = CNT_W'(BEATS - 1);

    if (!params_legal(WIDTH, LANES)) begin : g_param_check
        $error("sipo_deser: WIDTH must be a multiple of LANES, LANES in {1,2,4,8} and <= WIDTH");
    end

    logic [CNT_W-1:0] r_cnt;
    logic [WIDTH-1:0] w_q_next;
    logic             w_done;

    if (MSB_FIRST) begin : g_msb_first
        if (WIDTH == LANES) begin : g_single
            assign w_q_next = din;
        end else begin : g_shift
            assign w_q_next = {q[WIDTH-LANES-1:0], din};
        end
    end else begin : g_lsb_first
        // din[LANES-1] is earliest, so it must end up at the lowest index.
        logic [LANES-1:0] w_din_rev;
        always_comb begin
            w_din_rev = '0;
            for (int i = 0; i < LANES; i++) w_din_rev[i] = din[LANES-1-i];
        end
        if (WIDTH == LANES) begin : g_single
            assign w_q_next = w_din_rev;
        end else begin : g_shift
            assign w_q_next = {w_din_rev, q[WIDTH-1:LANES]};
        end
    end

    assign w_done = en && !clr && (r_cnt == LAST_BEAT);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            q     <= '0;
            r_cnt <= '0;
        end else if (clr) begin
            q     <= '0;
            r_cnt <= '0;
        end else if (en) begin
            q     <= w_q_next;
            r_cnt <= (r_cnt == LAST_BEAT) ? '0 : r_cnt + CNT_W'(1);
        end
    end

    sipo_out_reg #(
        .WIDTH (WIDTH)
    ) u_out_reg (
        .clk        (clk),
        .rst        (rst),
        .clr        (clr),
        .load       (w_done),
        .data       (w_q_next),
        .ready      (dout_ready),
        .dout       (dout),
        .dout_valid (dout_valid),
        .overrun    (overrun)
    );

endmodule
`default_nettype wire

// File: tb/tb_sipo_deser.sv
`default_nettype none
// ============================================================================
// Module   : tb_sipo_deser
// Purpose  : Scoreboard bench for sipo_deser (8-bit MSB-first main instance,
//            plus LSB-first and two-lane instances for ordering checks).
// Revision : 1.0
// ============================================================================
module tb_sipo_deser;

    logic       clk = 1'b0;
    logic       rst;
    logic       en;
    logic       clr;
    logic       dout_ready;
    logic       din1;
    logic [1:0] din2;

    logic [7:0] q_m, dout_m, q_l, dout_l, q_2, dout_2;
    logic       valid_m, ovr_m, valid_l, ovr_l, valid_2, ovr_2;

    int vectors = 0;
    int errors  = 0;

    // Reference model state for the main instance
    bit         mb[$];
    logic [7:0] exp_q[$];
    bit         m_held;
    bit         m_ovr;

    always #5 clk = ~clk;

    sipo_deser #(.WIDTH(8), .LANES(1), .MSB_FIRST(1'b1)) dut_m (
        .clk(clk), .rst(rst), .en(en), .din(din1), .clr(clr), .q(q_m),
        .dout(dout_m), .dout_valid(valid_m), .dout_ready(dout_ready), .overrun(ovr_m));

    sipo_deser #(.WIDTH(8), .LANES(1), .MSB_FIRST(1'b0)) dut_l (
        .clk(clk), .rst(rst), .en(en), .din(din1), .clr(clr), .q(q_l),
        .dout(dout_l), .dout_valid(valid_l), .dout_ready(dout_ready), .overrun(ovr_l));

    sipo_deser #(.WIDTH(8), .LANES(2), .MSB_FIRST(1'b1)) dut_2 (
        .clk(clk), .rst(rst), .en(en), .din(din2), .clr(clr), .q(q_2),
        .dout(dout_2), .dout_valid(valid_2), .dout_ready(dout_ready), .overrun(ovr_2));

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    // Monitor: a transfer happens at the next rising edge; pop and compare.
    always @(negedge clk) begin
        if (rst === 1'b0 && valid_m === 1'b1 && dout_ready === 1'b1) begin
            if (exp_q.size() == 0) begin
                vectors++;
                errors++;
                $display("FAIL unexpected_word: got 0x%0h expected none at %0t", dout_m, $time);
            end else begin
                check("dout_word", {24'd0, dout_m}, {24'd0, exp_q.pop_front()});
            end
        end
    end

    // One clock of stimulus on the main instance; the model follows the stream rules.
    task automatic step(input bit e, input bit d, input bit c, input bit r);
        bit         comp;
        logic [7:0] w;
        en = e; din1 = d; clr = c; dout_ready = r;
        comp = 1'b0;
        w    = '0;
        if (c) begin
            mb.delete();
        end else if (e) begin
            mb.push_back(d);
            if (mb.size() == 8) begin
                for (int i = 0; i < 8; i++) w[7-i] = mb[i];
                mb.delete();
                comp = 1'b1;
            end
        end
        if (m_held && r && !comp) m_held = 1'b0;
        if (comp) begin
            if (!m_held) begin
                m_held = 1'b1;
                exp_q.push_back(w);
            end else if (r) begin
                exp_q.push_back(w);
            end else begin
                m_ovr = 1'b1;
            end
        end
        if (c) m_ovr = 1'b0;
        @(posedge clk);
        #1;
        check("dout_valid", {31'd0, valid_m}, {31'd0, m_held});
        check("overrun", {31'd0, ovr_m}, {31'd0, m_ovr});
    endtask

    task automatic send_byte(input logic [7:0] b, input bit r);
        for (int i = 7; i >= 0; i--) step(1'b1, b[i], 1'b0, r);
    endtask

    task automatic do_reset();
        rst = 1'b1; en = 1'b0; clr = 1'b0;
        mb.delete(); exp_q.delete();
        m_held = 1'b0; m_ovr = 1'b0;
        #1;
        check("rst_q", {24'd0, q_m}, 32'd0);
        check("rst_dout", {24'd0, dout_m}, 32'd0);
        check("rst_valid", {31'd0, valid_m}, 32'd0);
        check("rst_overrun", {31'd0, ovr_m}, 32'd0);
        @(posedge clk);
        #1;
        rst = 1'b0;
    endtask

    initial begin
        logic [7:0] s;
        logic [1:0] l2 [4];
        s = 8'b1011_0010;
        l2[0] = 2'b11; l2[1] = 2'b00; l2[2] = 2'b10; l2[3] = 2'b01;

        rst = 1'b1; en = 1'b0; clr = 1'b0; dout_ready = 1'b0; din1 = 1'b0; din2 = 2'b00;
        m_held = 1'b0; m_ovr = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        check("reset_q", {24'd0, q_m}, 32'd0);
        check("reset_dout", {24'd0, dout_m}, 32'd0);
        check("reset_valid", {31'd0, valid_m}, 32'd0);
        check("reset_overrun", {31'd0, ovr_m}, 32'd0);
        rst = 1'b0;

        // Bit ordering across the three instances
        for (int i = 0; i < 8; i++) begin
            din2 = (i < 4) ? l2[i] : 2'b00;
            step(1'b1, s[7-i], 1'b0, 1'b1);
            if (i == 0) begin
                check("first_beat_q_msb", {24'd0, q_m}, 32'h01);
                check("first_beat_q_lsb", {24'd0, q_l}, 32'h80);
            end
            if (i == 3) begin
                check("lanes2_dout", {24'd0, dout_2}, 32'hC9);
                check("lanes2_valid", {31'd0, valid_2}, 32'd1);
            end
        end
        check("msb_dout", {24'd0, dout_m}, 32'hB2);
        check("lsb_dout", {24'd0, dout_l}, 32'h4D);
        check("lsb_valid", {31'd0, valid_l}, 32'd1);
        step(1'b0, 1'b0, 1'b0, 1'b1);

        // Overrun: second word dropped while the first is held
        send_byte(8'hB2, 1'b0);
        send_byte(8'h4D, 1'b0);
        check("overrun_dout_held", {24'd0, dout_m}, 32'hB2);
        step(1'b0, 1'b0, 1'b0, 1'b1);
        step(1'b0, 1'b0, 1'b1, 1'b0);

        // en gap inside a word
        step(1'b1, 1'b1, 1'b0, 1'b1);
        step(1'b1, 1'b1, 1'b0, 1'b1);
        step(1'b1, 1'b0, 1'b0, 1'b1);
        step(1'b1, 1'b1, 1'b0, 1'b1);
        for (int i = 0; i < 3; i++) begin
            step(1'b0, 1'($urandom), 1'b0, 1'b1);
            check("gap_q", {24'd0, q_m}, 32'h0D);
        end
        step(1'b1, 1'b0, 1'b0, 1'b1);
        step(1'b1, 1'b1, 1'b0, 1'b1);
        step(1'b1, 1'b1, 1'b0, 1'b1);
        step(1'b1, 1'b0, 1'b0, 1'b1);
        check("gap_word_q", {24'd0, q_m}, 32'hD6);
        step(1'b0, 1'b0, 1'b0, 1'b1);

        // Reset mid-word
        for (int i = 0; i < 5; i++) step(1'b1, 1'($urandom), 1'b0, 1'b1);
        do_reset();
        send_byte(8'hA5, 1'b1);
        check("after_reset_q", {24'd0, q_m}, 32'hA5);
        step(1'b0, 1'b0, 1'b0, 1'b1);

        // clr on beat 3 discards that beat
        for (int i = 0; i < 3; i++) step(1'b1, 1'($urandom), 1'b0, 1'b1);
        step(1'b1, 1'b1, 1'b1, 1'b1);
        check("clr_q", {24'd0, q_m}, 32'd0);
        send_byte(8'h3C, 1'b1);
        step(1'b0, 1'b0, 1'b0, 1'b1);

        // Randomized traffic
        for (int i = 0; i < 400; i++) begin
            step(($urandom_range(3) != 0), 1'($urandom), ($urandom_range(49) == 0),
                 1'($urandom));
        end

        repeat (2) step(1'b0, 1'b0, 1'b0, 1'b1);
        check("scoreboard_drained", exp_q.size(), 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
        $finish;
    end

endmodule
`default_nettype wire
